// File: rtl/rgb2ycbcr_pkg.sv
// Shared constants for the RGB->YCbCr block converter: Q16 reference coefficients,
// their rescaling to any fractional width, the chroma/luma offset and the FSM states.
package rgb2ycbcr_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_e;

  localparam int REF_FB = 16;

  // Q16 coefficients; chosen so every row sums exactly (65536, 0, 0)
  localparam longint C_YR  = 19595;
  localparam longint C_YG  = 38470;
  localparam longint C_YB  = 7471;
  localparam longint C_CBR = -11059;
  localparam longint C_CBG = -21709;
  localparam longint C_CBB = 32768;
  localparam longint C_CRR = 32768;
  localparam longint C_CRG = -27439;
  localparam longint C_CRB = -5329;

  localparam longint OFF = 64'sd128 <<< REF_FB;

  function automatic longint coef(input longint c, input int fb);
    if (fb >= REF_FB) return c <<< (fb - REF_FB);
    return (c + (64'sd1 <<< (REF_FB - fb - 1))) >>> (REF_FB - fb);
  endfunction

  function automatic longint off_at(input int fb);
    return 64'sd128 <<< fb;
  endfunction

endpackage

// File: rtl/rgb2ycbcr_core.sv
// One-pixel colour converter: three exact fixed-point dot products, registered once.
module rgb2ycbcr_core import rgb2ycbcr_pkg::*; #(
  parameter int INPUT_WIDTH        = 8,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int FRAC_BITS          = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic        [INPUT_WIDTH-1:0]        r,
  input  logic        [INPUT_WIDTH-1:0]        g,
  input  logic        [INPUT_WIDTH-1:0]        b,
  input  logic                                 level_shift,
  output logic signed [FIXED_POINT_LENGTH-1:0] y_q,
  output logic signed [FIXED_POINT_LENGTH-1:0] cb_q,
  output logic signed [FIXED_POINT_LENGTH-1:0] cr_q
);
  localparam int W = FIXED_POINT_LENGTH;
  localparam logic signed [W-1:0] K_YR  = W'(coef(C_YR,  FRAC_BITS));
  localparam logic signed [W-1:0] K_YG  = W'(coef(C_YG,  FRAC_BITS));
  localparam logic signed [W-1:0] K_YB  = W'(coef(C_YB,  FRAC_BITS));
  localparam logic signed [W-1:0] K_CBR = W'(coef(C_CBR, FRAC_BITS));
  localparam logic signed [W-1:0] K_CBG = W'(coef(C_CBG, FRAC_BITS));
  localparam logic signed [W-1:0] K_CBB = W'(coef(C_CBB, FRAC_BITS));
  localparam logic signed [W-1:0] K_CRR = W'(coef(C_CRR, FRAC_BITS));
  localparam logic signed [W-1:0] K_CRG = W'(coef(C_CRG, FRAC_BITS));
  localparam logic signed [W-1:0] K_CRB = W'(coef(C_CRB, FRAC_BITS));
  localparam logic signed [W-1:0] K_OFF = W'(off_at(FRAC_BITS));

  logic signed [W-1:0] rs, gs, bs, sy, scb, scr, y_d, cb_d, cr_d;

  // Headroom of two bits above INPUT_WIDTH+FRAC_BITS keeps every sum exact
  always_comb begin
    rs   = $signed(W'(r));
    gs   = $signed(W'(g));
    bs   = $signed(W'(b));
    sy   = rs * K_YR  + gs * K_YG  + bs * K_YB;
    scb  = rs * K_CBR + gs * K_CBG + bs * K_CBB;
    scr  = rs * K_CRR + gs * K_CRG + bs * K_CRB;
    y_d  = level_shift ? sy - K_OFF : sy;
    cb_d = level_shift ? scb : scb + K_OFF;
    cr_d = level_shift ? scr : scr + K_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q  <= '0;
      cb_q <= '0;
      cr_q <= '0;
    end else begin
      y_q  <= y_d;
      cb_q <= cb_d;
      cr_q <= cr_d;
    end
  end

endmodule

// File: rtl/rgb2ycbcr_stream_container.sv
// Block-level RGB->YCbCr converter: captures a PIXEL_COUNT block on a valid/ready
// handshake, sweeps it through CORE_COUNT cores in batches and holds the result.
module rgb2ycbcr_stream_container import rgb2ycbcr_pkg::*; #(
  parameter int INPUT_WIDTH        = 8,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int FRAC_BITS          = 16,
  parameter int PIXEL_COUNT        = 64,
  parameter int CORE_COUNT         = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      level_shift,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0]        r_all,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0]        g_all,
  input  logic [INPUT_WIDTH*PIXEL_COUNT-1:0]        b_all,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] y_all,
  output logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] cb_all,
  output logic [FIXED_POINT_LENGTH*PIXEL_COUNT-1:0] cr_all,
  output logic                                      busy
);
  localparam int IW = INPUT_WIDTH;
  localparam int FW = FIXED_POINT_LENGTH;
  localparam int NB = PIXEL_COUNT / CORE_COUNT;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IB = IW * PIXEL_COUNT;
  localparam int OB = FW * PIXEL_COUNT;

  if ((PIXEL_COUNT % CORE_COUNT) != 0 || (INPUT_WIDTH + FRAC_BITS + 2) > FIXED_POINT_LENGTH)
  begin : g_bad_params
    $error("rgb2ycbcr_stream_container: illegal parameter combination");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, wr_idx_q, wr_idx_d;
  logic            wr_vld_q, wr_vld_d, ls_q, ls_d, accept;
  logic [IB-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic [OB-1:0]   y_q, y_d, cb_q, cb_d, cr_q, cr_d;
  logic [CORE_COUNT-1:0][IW-1:0] px_r, px_g, px_b;
  logic [CORE_COUNT-1:0][FW-1:0] core_y, core_cb, core_cr;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = RUN;
      RUN:   if (cnt_q == CW'(NB - 1)) state_d = DRAIN;
      DRAIN: state_d = HOLD;
      HOLD:  if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // in_ready follows out_ready in HOLD so a release and a new accept share one edge
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin in_ready = 1'b1; busy = 1'b0; end
      HOLD: begin in_ready = out_ready; out_valid = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    r_d = r_q; g_d = g_q; b_d = b_q; ls_d = ls_q; cnt_d = cnt_q;
    if (accept) begin
      r_d = r_all; g_d = g_all; b_d = b_all; ls_d = level_shift; cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = (cnt_q == CW'(NB - 1)) ? '0 : cnt_q + 1'b1;
    end
    wr_vld_d = (state_q == RUN);
    wr_idx_d = cnt_q;
    for (int k = 0; k < CORE_COUNT; k++) begin
      px_r[k] = r_q[(int'(cnt_q) * CORE_COUNT + k) * IW +: IW];
      px_g[k] = g_q[(int'(cnt_q) * CORE_COUNT + k) * IW +: IW];
      px_b[k] = b_q[(int'(cnt_q) * CORE_COUNT + k) * IW +: IW];
    end
  end

  // Core results lag the presented batch by one edge; wr_idx_q tracks which batch
  always_comb begin
    y_d = y_q; cb_d = cb_q; cr_d = cr_q;
    if (wr_vld_q) begin
      for (int k = 0; k < CORE_COUNT; k++) begin
        y_d [(int'(wr_idx_q) * CORE_COUNT + k) * FW +: FW] = core_y[k];
        cb_d[(int'(wr_idx_q) * CORE_COUNT + k) * FW +: FW] = core_cb[k];
        cr_d[(int'(wr_idx_q) * CORE_COUNT + k) * FW +: FW] = core_cr[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0; wr_idx_q <= '0; wr_vld_q <= 1'b0; ls_q <= 1'b0;
      r_q <= '0; g_q <= '0; b_q <= '0;
      y_q <= '0; cb_q <= '0; cr_q <= '0;
    end else begin
      cnt_q <= cnt_d; wr_idx_q <= wr_idx_d; wr_vld_q <= wr_vld_d; ls_q <= ls_d;
      r_q <= r_d; g_q <= g_d; b_q <= b_d;
      y_q <= y_d; cb_q <= cb_d; cr_q <= cr_d;
    end
  end

  for (genvar k = 0; k < CORE_COUNT; k++) begin : g_core
    rgb2ycbcr_core #(
      .INPUT_WIDTH       (INPUT_WIDTH),
      .FIXED_POINT_LENGTH(FIXED_POINT_LENGTH),
      .FRAC_BITS         (FRAC_BITS)
    ) u_core (
      .clk        (clk),
      .rst        (rst),
      .r          (px_r[k]),
      .g          (px_g[k]),
      .b          (px_b[k]),
      .level_shift(ls_q),
      .y_q        (core_y[k]),
      .cb_q       (core_cb[k]),
      .cr_q       (core_cr[k])
    );
  end

  assign y_all  = y_q;
  assign cb_all = cb_q;
  assign cr_all = cr_q;

endmodule
